// File: rtl/regfile_sb.sv
// Integer register file with zero-latency read ports, same-cycle write-back bypass,
// and a per-register pending-writer scoreboard that drives decode stall/issue backpressure.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int PEND_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r1_enable_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    output logic [DATA_W-1:0] r1_data_o,
    input  logic              r2_enable_i,
    input  logic [ADDR_W-1:0] r2_addr_i,
    output logic [DATA_W-1:0] r2_data_o,
    input  logic              w_enable_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    output logic              issue_ready_o,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              err_o
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0][PEND_W-1:0] cnt_q, cnt_d;
    logic                            err_q, err_d;

    logic                   wb_nz;
    logic [1:0]             rd_en;
    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;
    logic [1:0]             rd_stall;

    assign wb_nz      = w_enable_i && (w_addr_i != '0);
    assign rd_en      = {r2_enable_i, r1_enable_i};
    assign rd_addr    = {r2_addr_i, r1_addr_i};
    assign r1_data_o  = rd_data[0];
    assign r2_data_o  = rd_data[1];
    assign stall_o    = |rd_stall;
    assign err_o      = err_q;

    // A write-back on the target frees a slot in the same cycle, so a full counter can still accept.
    assign issue_ready_o = rst && (flush_i || (issue_addr_i == '0) ||
                                   (cnt_q[issue_addr_i] != CNT_MAX) ||
                                   (w_enable_i && (w_addr_i == issue_addr_i)));

    always_comb begin
        logic dec_hit;
        rd_data  = '0;
        rd_stall = '0;
        for (int p = 0; p < 2; p++) begin
            dec_hit = wb_nz && (w_addr_i == rd_addr[p]);
            if (rst && rd_en[p] && (rd_addr[p] != '0)) begin
                rd_data[p]  = dec_hit ? w_data_i : regs_q[rd_addr[p]];
                // Stall only if a writer remains after the one retiring this cycle.
                rd_stall[p] = cnt_q[rd_addr[p]] > {{(PEND_W-1){1'b0}}, dec_hit};
            end
        end
    end

    always_comb begin
        logic inc, dec;
        regs_d = regs_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        inc    = 1'b0;
        dec    = 1'b0;
        if (wb_nz) regs_d[w_addr_i] = w_data_i;
        for (int a = 1; a < NUM_REGS; a++) begin
            inc = issue_valid_i && issue_ready_o && (issue_addr_i == ADDR_W'(a));
            dec = wb_nz && (w_addr_i == ADDR_W'(a));
            if (flush_i) begin
                cnt_d[a] = '0;
            end else if (inc && !dec) begin
                cnt_d[a] = cnt_q[a] + PEND_W'(1);
            end else if (dec && !inc) begin
                if (cnt_q[a] == '0) err_d = 1'b1;
                else                cnt_d[a] = cnt_q[a] - PEND_W'(1);
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: array-based scoreboard model checked every negedge,
// plus literal spot checks that pin the model to hand-computed values.
module tb_regfile_sb;
    localparam int DW = 32, AW = 5, NR = 32, PW = 2;
    localparam int MAXC = (1 << PW) - 1;

    logic          clk = 1'b0, rst = 1'b0;
    logic          r1_en = 0, r2_en = 0, w_en = 0, iv = 0, flush = 0;
    logic [AW-1:0] r1_a = 0, r2_a = 0, w_a = 0, ia = 0;
    logic [DW-1:0] w_d = 0;
    logic [DW-1:0] r1_d, r2_d;
    logic          ready, stall, err;

    int errors = 0, checks = 0;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .PEND_W(PW)) dut (
        .clk(clk), .rst(rst),
        .r1_enable_i(r1_en), .r1_addr_i(r1_a), .r1_data_o(r1_d),
        .r2_enable_i(r2_en), .r2_addr_i(r2_a), .r2_data_o(r2_d),
        .w_enable_i(w_en), .w_addr_i(w_a), .w_data_i(w_d),
        .issue_valid_i(iv), .issue_addr_i(ia), .issue_ready_o(ready),
        .flush_i(flush), .stall_o(stall), .err_o(err)
    );

    always #5 clk = ~clk;

    // Model state: architectural values, outstanding-writer counts, sticky error.
    logic [DW-1:0] m_reg [NR];
    int            m_cnt [NR];
    logic          m_err;

    function automatic bit wb_on(input logic [AW-1:0] a);
        return w_en && w_a == a && a != 0;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic en, input logic [AW-1:0] a);
        if (!rst || !en || a == 0) return '0;
        return wb_on(a) ? w_d : m_reg[a];
    endfunction

    function automatic bit exp_stall_port(input logic en, input logic [AW-1:0] a);
        int left;
        if (!rst || !en || a == 0) return 0;
        left = m_cnt[a] - (wb_on(a) ? 1 : 0);
        return left > 0;
    endfunction

    function automatic bit exp_ready();
        if (!rst) return 0;
        return flush || ia == 0 || m_cnt[ia] < MAXC || (w_en && w_a == ia);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i] <= '0;
                m_cnt[i] <= 0;
            end
            m_err <= 1'b0;
        end else begin
            if (w_en && w_a != 0) m_reg[w_a] <= w_d;
            for (int i = 1; i < NR; i++) begin
                int delta;
                delta = ((iv && exp_ready() && ia == i) ? 1 : 0) - (wb_on(AW'(i)) ? 1 : 0);
                if (flush)                          m_cnt[i] <= 0;
                else if (delta == 1)                m_cnt[i] <= m_cnt[i] + 1;
                else if (delta == -1 && m_cnt[i] == 0) m_err <= 1'b1;
                else if (delta == -1)               m_cnt[i] <= m_cnt[i] - 1;
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("r1_data", r1_d, exp_rd(r1_en, r1_a));
        check("r2_data", r2_d, exp_rd(r2_en, r2_a));
        check("stall", {31'b0, stall},
              {31'b0, exp_stall_port(r1_en, r1_a) || exp_stall_port(r2_en, r2_a)});
        check("issue_ready", {31'b0, ready}, {31'b0, exp_ready()});
        check("err", {31'b0, err}, {31'b0, m_err});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r1_en = 0; r2_en = 0; w_en = 0; iv = 0; flush = 0;
    endtask

    initial begin
        // Held in reset: outputs must be 0 even with requests present.
        r1_en = 1; r1_a = 5; iv = 1; ia = 3;
        #3;
        check("rst_r1", r1_d, 0);
        check("rst_ready", {31'b0, ready}, 0);
        #9 rst = 1;
        idle();
        step();

        // 1: basic reads after reset
        r1_en = 1; r1_a = 5; r2_en = 1; r2_a = 0;
        #1;
        check("t1_r1", r1_d, 0); check("t1_r2", r2_d, 0);
        check("t1_stall", {31'b0, stall}, 0); check("t1_err", {31'b0, err}, 0);
        step();

        // 2: unreserved write-back -> bypass, then underflow error
        r1_a = 7; w_en = 1; w_a = 7; w_d = 32'hDEADBEEF;
        #1 check("t2_bypass", r1_d, 32'hDEADBEEF);
        step();
        w_en = 0;
        #1 check("t2_err", {31'b0, err}, 1);
        check("t2_stored", r1_d, 32'hDEADBEEF);
        step();

        // 3: reserve x3, stall until its write-back
        idle(); iv = 1; ia = 3;
        step();
        iv = 0; r1_en = 1; r1_a = 3;
        #1 check("t3_stall", {31'b0, stall}, 1);
        step();
        w_en = 1; w_a = 3; w_d = 32'h12;
        #1 check("t3_wb_stall", {31'b0, stall}, 0);
        check("t3_wb_data", r1_d, 32'h12);
        step();
        w_en = 0;
        #1 check("t3_after", {31'b0, stall}, 0);
        step();

        // 4: saturate x4
        idle(); iv = 1; ia = 4;
        for (int i = 0; i < 3; i++) begin
            #1 check("t4_ready_fill", {31'b0, ready}, 1);
            step();
        end
        #1 check("t4_ready_full", {31'b0, ready}, 0);
        step();
        w_en = 1; w_a = 4; w_d = 32'h44; r1_en = 1; r1_a = 4;
        #1 check("t4_ready_wb", {31'b0, ready}, 1);
        check("t4_bypass", r1_d, 32'h44);
        check("t4_older_stall", {31'b0, stall}, 1);
        step();
        w_en = 0;
        #1 check("t4_still_full", {31'b0, ready}, 0);
        step();

        // fresh reset so the sticky error starts clear
        idle();
        #2 rst = 0;
        #1 check("mid_rst_err", {31'b0, err}, 0);
        #2 rst = 1;
        step();

        // 5: flush with concurrent write-back, then a flush hiding an underflow
        iv = 1; ia = 9;  step();
        ia = 10; step();
        iv = 0; flush = 1; w_en = 1; w_a = 9; w_d = 32'h55;
        step();
        w_a = 12; w_d = 32'h77;
        step();
        idle(); r1_en = 1; r1_a = 10; r2_en = 1; r2_a = 9;
        #1 check("t5_stall", {31'b0, stall}, 0);
        check("t5_x9", r2_d, 32'h55);
        check("t5_err", {31'b0, err}, 0);
        step();

        // 6: x0 writes and reservations are inert; async reset drops outputs
        idle(); w_en = 1; w_a = 0; w_d = 32'hFFFFFFFF; iv = 1; ia = 0;
        r1_en = 1; r1_a = 0; r2_en = 1; r2_a = 0;
        #1 check("t6_r1", r1_d, 0); check("t6_stall", {31'b0, stall}, 0);
        check("t6_ready", {31'b0, ready}, 1);
        step();
        idle(); w_en = 1; w_a = 5; w_d = 32'hABC; step();
        w_en = 0; iv = 1; ia = 5; step();
        iv = 0; r1_en = 1; r1_a = 5; ia = 5;
        #1 check("t6_pre_data", r1_d, 32'hABC);
        check("t6_pre_stall", {31'b0, stall}, 1);
        #1 rst = 0;
        #1 check("t6_rst_data", r1_d, 0);
        check("t6_rst_stall", {31'b0, stall}, 0);
        check("t6_rst_ready", {31'b0, ready}, 0);
        step();
        rst = 1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file with a pending-write scoreboard. It is the responder to the decode stage's two register read ports and the sink for the write-back stage's single write port.
- Returns operand data combinationally, with same-cycle write-back bypass.
- Tracks in-flight writers per register and asserts a stall when a requested operand is not yet produced.
- Sits beside the decode stage; decode reserves each issued instruction's destination register.

Parameters:
- DATA_W, 32, register width (matches RegBus)
- ADDR_W, 5, register address width (matches RegAddrBus)
- NUM_REGS, 32, number of architectural registers; x0 hardwired to zero
- PEND_W, 2, width of each per-register pending counter; max outstanding writers per register = 2^PEND_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- r1_enable_i  in  1  read port 1 request
- r1_addr_i  in  ADDR_W  read port 1 address
- r1_data_o  out  DATA_W  read port 1 data
- r2_enable_i  in  1  read port 2 request
- r2_addr_i  in  ADDR_W  read port 2 address
- r2_data_o  out  DATA_W  read port 2 data
- w_enable_i  in  1  write-back valid
- w_addr_i  in  ADDR_W  write-back address
- w_data_i  in  DATA_W  write-back data
- issue_valid_i  in  1  decode issued an instruction that writes issue_addr_i
- issue_addr_i  in  ADDR_W  destination to reserve
- issue_ready_o  out  1  reservation can be accepted this cycle
- flush_i  in  1  squash all in-flight reservations
- stall_o  out  1  an enabled read hits a pending register
- err_o  out  1  sticky: write-back released a register with zero pending count

Behaviour:
- Reset (rst=0, async): all registers 0; all pending counters 0; err_o=0. While in reset, r1_data_o/r2_data_o/stall_o read 0 and issue_ready_o reads 0.
- Read port n (combinational, zero latency):
  - rn_enable_i=0 -> 0.
  - address 0 -> 0.
  - Else, if w_enable_i && w_addr_i==rn_addr_i && w_addr_i!=0 -> w_data_i (bypass).
  - Else -> stored value.
- Write: on clk, if w_enable_i && w_addr_i!=0, reg[w_addr_i] <= w_data_i. Writes to x0 are dropped.
- Pending counter cnt[a], per register, for a != 0:
  - inc = issue_valid_i && issue_ready_o && issue_addr_i==a && a!=0.
  - dec = w_enable_i && w_addr_i==a && a!=0.
  - inc&&dec -> unchanged. inc only -> +1. dec only -> -1.
  - dec with cnt==0 (and no inc) -> stays 0 and err_o <= 1 (sticky until reset).
  - cnt[0] is constant 0.
- flush_i=1: all counters <= 0 on the clock edge, overriding inc/dec. The write-back data write in the same cycle still commits. The underflow check is suppressed that cycle.
- issue_ready_o = (issue_addr_i==0) || cnt[issue_addr_i] != max || dec on issue_addr_i this cycle. It is combinational and is 1 while flush_i=1.
- Issue with issue_ready_o=0 is ignored: no counter change.
- stall_o = OR over ports of (rn_enable_i && rn_addr_i!=0 && eff_cnt(rn_addr_i)!=0).
  - eff_cnt = cnt minus 1 if dec hits that address this cycle.
  - Stall clears in the same cycle as the final write-back (bypass supplies data).
  - stall_o ignores the same-cycle issue, so decode's own reservation never self-stalls its reads.
- Read-after-write same cycle with cnt=2 before dec: data is bypassed but stall_o=1, because an older writer is still pending.

Test Plan:
1. Reset, then read r1_addr=5, r2_addr=0 with both enables set -> both data 0, stall_o=0, err_o=0.
2. Write x7=0xDEADBEEF with no prior reserve. In the same cycle read x7 -> r1_data_o=0xDEADBEEF (bypass). Next cycle err_o=1 (underflow); later read returns 0xDEADBEEF.
3. Reserve x3. Next cycle read x3 -> stall_o=1. Write-back x3=0x12 in a later cycle -> stall_o=0 and r1_data_o=0x12 in that cycle; cnt[3]=0 after.
4. Reserve x4 three times -> issue_ready_o=0 on the 4th attempt for x4 and cnt stays 3. Same cycle as a WB to x4 -> issue_ready_o=1 and cnt stays 3.
5. Reserve x9 and x10, then assert flush_i together with a WB x9=0x55 -> all counters 0, x9=0x55, err_o stays 0, reads of x10 not stalled.
6. Write x0=0xFFFFFFFF and reserve x0 -> reads of x0 return 0, stall_o=0, issue_ready_o=1. Assert rst low mid-sequence -> outputs drop to 0 immediately.
